// File: rtl/ip_pkg.sv
// ip_pkg: shared definitions for the IPv4 header checker.
//   - error codes reported on hdr_err
//   - FSM state encoding
//   - fixed header field offsets and constants
//   - captured header field record
//   - one ones'-complement add step with end-around carry
package ip_pkg;

    typedef enum logic [2:0] {
        IP_ERR_NONE  = 3'd0,
        IP_ERR_VER   = 3'd1,
        IP_ERR_CSUM  = 3'd2,
        IP_ERR_TRUNC = 3'd3,
        IP_ERR_DST   = 3'd4
    } ip_err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } ip_state_e;

    localparam logic [3:0]  IP_VERSION  = 4'd4;
    localparam logic [3:0]  IHL_MIN     = 4'd5;

    localparam logic [15:0] OFF_TLEN_HI = 16'd2;
    localparam logic [15:0] OFF_TLEN_LO = 16'd3;
    localparam logic [15:0] OFF_PROTO   = 16'd9;
    localparam logic [15:0] OFF_SRC     = 16'd12;
    localparam logic [15:0] OFF_DST     = 16'd16;
    localparam logic [15:0] OFF_FIX_END = 16'd20;  // first byte after the fixed header

    typedef struct packed {
        logic [7:0]  proto;
        logic [15:0] total_len;
        logic [31:0] src;
        logic [31:0] dst;
    } ip_fields_t;

    // acc + term with the carry out of bit 15 wrapped back into bit 0.
    // Both inputs are <= 16'hFFFF, so the wrapped result never carries again.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] term);
        logic [16:0] t;
        t = {1'b0, acc} + {1'b0, term};
        return t[15:0] + {15'd0, t[16]};
    endfunction

endpackage

// File: rtl/csum16_acc.sv
// csum16_acc: byte-serial ones'-complement accumulator.
//   clk   in   clock
//   rst   in   asynchronous active-low reset
//   clr   in   restart at 0 with even phase (a byte with en in the same cycle
//              is added as the first, even-offset byte)
//   en    in   add data this cycle
//   data  in   8-bit byte
//   sum   out  17-bit accumulator; the carry is folded on every add, so bit 16 stays 0
// Even-offset bytes are the high half of a 16-bit word, odd-offset bytes the low half.
module csum16_acc
    import ip_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [16:0] sum
);

    logic [15:0] acc_q, acc_d;
    logic        odd_q, odd_d;
    logic [15:0] base;
    logic        phase;

    always_comb begin
        base  = clr ? 16'd0 : acc_q;
        phase = clr ? 1'b0  : odd_q;
        acc_d = base;
        odd_d = phase;
        if (en) begin
            acc_d = csum_add(base, phase ? {8'h00, data} : {data, 8'h00});
            odd_d = ~phase;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= 16'd0;
            odd_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            odd_q <= odd_d;
        end
    end

    assign sum = {1'b0, acc_q};

endmodule

// File: rtl/ip_hdr_check.sv
// ip_hdr_check: IPv4 header checker between the MAC deframer and the UDP parser.
// Checks version/IHL, header checksum, total length and destination address,
// publishes the header fields, and forwards the payload trimmed to total_len.
//   clk, rst               clock; asynchronous active-low reset
//   rx_valid/data/sof/eof  input byte stream (gaps allowed, no backpressure)
//   hdr_done               1-cycle verdict pulse
//   hdr_ok, hdr_err        verdict and error code, valid with hdr_done
//   ip_proto, ip_total_len, ip_src, ip_dst   fields, held until the next hdr_done
//   pl_valid, pl_data, pl_last               payload stream, 1-cycle latency
module ip_hdr_check
    import ip_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_00C7,
    parameter bit          DST_FILTER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic        hdr_done,
    output logic        hdr_ok,
    output logic [2:0]  hdr_err,
    output logic [7:0]  ip_proto,
    output logic [15:0] ip_total_len,
    output logic [31:0] ip_src,
    output logic [31:0] ip_dst,
    output logic        pl_valid,
    output logic [7:0]  pl_data,
    output logic        pl_last
);

    ip_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;          // offset of the byte arriving next
    logic [15:0] hdr_len_q, hdr_len_d;
    ip_fields_t  wk_q, wk_d;            // fields of the packet in flight
    ip_fields_t  pub_q, pub_d;          // fields published at hdr_done
    logic        hdr_done_q, hdr_done_d;
    logic        hdr_ok_q, hdr_ok_d;
    ip_err_e     hdr_err_q, hdr_err_d;
    logic        pl_valid_q, pl_valid_d;
    logic [7:0]  pl_data_q, pl_data_d;
    logic        pl_last_q, pl_last_d;

    logic        csum_clr, csum_en;
    logic [16:0] csum_sum;
    logic [15:0] csum_fin;
    logic        hdr_last, pl_end;

    csum16_acc u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  (csum_clr),
        .en   (csum_en),
        .data (rx_data),
        .sum  (csum_sum)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_len_d  = hdr_len_q;
        wk_d       = wk_q;
        pub_d      = pub_q;
        hdr_done_d = 1'b0;
        hdr_ok_d   = hdr_ok_q;
        hdr_err_d  = hdr_err_q;
        pl_valid_d = 1'b0;
        pl_data_d  = pl_data_q;
        pl_last_d  = 1'b0;
        csum_clr   = 1'b0;
        csum_en    = 1'b0;

        hdr_last = (cnt_q == hdr_len_q - 16'd1);
        pl_end   = (cnt_q == wk_q.total_len - 16'd1);
        // The last header byte always sits at an odd offset (hdr_len is a
        // multiple of 4), so it is the low half of the final word.
        csum_fin = csum_add(csum_add(csum_sum[15:0], {15'd0, csum_sum[16]}), {8'h00, rx_data});

        if (rx_valid && rx_sof) begin
            // sof restarts from any state; an unfinished packet is abandoned silently
            csum_clr  = 1'b1;
            csum_en   = 1'b1;
            cnt_d     = 16'd1;
            wk_d      = '0;
            hdr_len_d = {10'd0, rx_data[3:0], 2'b00};
            if (rx_data[7:4] != IP_VERSION || rx_data[3:0] < IHL_MIN) begin
                hdr_done_d = 1'b1;
                hdr_ok_d   = 1'b0;
                hdr_err_d  = IP_ERR_VER;
                pub_d      = wk_d;
                state_d    = rx_eof ? ST_IDLE : ST_DROP;
            end else if (rx_eof) begin
                hdr_done_d = 1'b1;
                hdr_ok_d   = 1'b0;
                hdr_err_d  = IP_ERR_TRUNC;
                pub_d      = wk_d;
                state_d    = ST_IDLE;
            end else begin
                state_d = ST_HDR;
            end
        end else if (rx_valid) begin
            case (state_q)
                ST_HDR: begin
                    csum_en = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_q == OFF_TLEN_HI) wk_d.total_len[15:8] = rx_data;
                    if (cnt_q == OFF_TLEN_LO) wk_d.total_len[7:0]  = rx_data;
                    if (cnt_q == OFF_PROTO)   wk_d.proto           = rx_data;
                    if (cnt_q >= OFF_SRC && cnt_q < OFF_DST)
                        wk_d.src = {wk_q.src[23:0], rx_data};
                    if (cnt_q >= OFF_DST && cnt_q < OFF_FIX_END)
                        wk_d.dst = {wk_q.dst[23:0], rx_data};

                    if (hdr_last) begin
                        hdr_done_d = 1'b1;
                        hdr_ok_d   = 1'b0;
                        pub_d      = wk_d;
                        if (csum_fin != 16'hFFFF)
                            hdr_err_d = IP_ERR_CSUM;
                        else if (wk_d.total_len < hdr_len_q)
                            hdr_err_d = IP_ERR_VER;
                        else if (DST_FILTER && wk_d.dst != LOCAL_IP)
                            hdr_err_d = IP_ERR_DST;
                        else begin
                            hdr_err_d = IP_ERR_NONE;
                            hdr_ok_d  = 1'b1;
                        end
                        // a frame ending on its last header byte has nothing left to drop
                        if (rx_eof)
                            state_d = ST_IDLE;
                        else if (hdr_ok_d && wk_d.total_len != hdr_len_q)
                            state_d = ST_PAYLOAD;
                        else
                            state_d = ST_DROP;
                    end else if (rx_eof) begin
                        hdr_done_d = 1'b1;
                        hdr_ok_d   = 1'b0;
                        hdr_err_d  = IP_ERR_TRUNC;
                        pub_d      = wk_d;
                        state_d    = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    cnt_d      = cnt_q + 16'd1;
                    pl_valid_d = 1'b1;
                    pl_data_d  = rx_data;
                    // short frames mark their final byte as last
                    pl_last_d  = pl_end || rx_eof;
                    if (rx_eof)
                        state_d = ST_IDLE;
                    else if (pl_end)
                        state_d = ST_DROP;
                end
                ST_DROP: begin
                    if (rx_eof) state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            hdr_len_q  <= 16'd0;
            wk_q       <= '0;
            pub_q      <= '0;
            hdr_done_q <= 1'b0;
            hdr_ok_q   <= 1'b0;
            hdr_err_q  <= IP_ERR_NONE;
            pl_valid_q <= 1'b0;
            pl_data_q  <= 8'd0;
            pl_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_len_q  <= hdr_len_d;
            wk_q       <= wk_d;
            pub_q      <= pub_d;
            hdr_done_q <= hdr_done_d;
            hdr_ok_q   <= hdr_ok_d;
            hdr_err_q  <= hdr_err_d;
            pl_valid_q <= pl_valid_d;
            pl_data_q  <= pl_data_d;
            pl_last_q  <= pl_last_d;
        end
    end

    assign hdr_done     = hdr_done_q;
    assign hdr_ok       = hdr_ok_q;
    assign hdr_err      = hdr_err_q;
    assign ip_proto     = pub_q.proto;
    assign ip_total_len = pub_q.total_len;
    assign ip_src       = pub_q.src;
    assign ip_dst       = pub_q.dst;
    assign pl_valid     = pl_valid_q;
    assign pl_data      = pl_data_q;
    assign pl_last      = pl_last_q;

endmodule

// File: tb/tb_ip_hdr_check.sv
// tb_ip_hdr_check: drives IPv4 frames (directed and random, with gaps) into
// ip_hdr_check and checks verdicts, fields and payload against a reference
// model that parses each frame as a whole byte array.
module tb_ip_hdr_check;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8_00C7;

    typedef struct packed {
        logic        ok;
        logic [2:0]  err;
        logic [7:0]  proto;
        logic [15:0] tl;
        logic [31:0] src;
        logic [31:0] dst;
    } hev_t;

    logic        clk, rst, rx_valid, rx_sof, rx_eof;
    logic [7:0]  rx_data;
    logic        hdr_done, hdr_ok, pl_valid, pl_last;
    logic [2:0]  hdr_err;
    logic [7:0]  ip_proto, pl_data;
    logic [15:0] ip_total_len;
    logic [31:0] ip_src, ip_dst;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt[$];
    hev_t       exp_hdr[$], obs_hdr[$];
    logic [8:0] exp_pl[$],  obs_pl[$];

    ip_hdr_check dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .hdr_done(hdr_done), .hdr_ok(hdr_ok),
        .hdr_err(hdr_err), .ip_proto(ip_proto), .ip_total_len(ip_total_len),
        .ip_src(ip_src), .ip_dst(ip_dst), .pl_valid(pl_valid), .pl_data(pl_data),
        .pl_last(pl_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: outputs sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            if (hdr_done) obs_hdr.push_back(hev_t'({hdr_ok, hdr_err, ip_proto, ip_total_len, ip_src, ip_dst}));
            if (pl_valid) obs_pl.push_back({pl_last, pl_data});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // header builder: checksum computed from its arithmetic definition
    task automatic build(input int ihl, input int tl, input logic [7:0] proto,
                         input logic [31:0] src, input logic [31:0] dst, input int plen);
        int s;
        logic [7:0] b0;
        b0 = {4'd4, 4'(ihl)};
        pkt.delete();
        pkt.push_back(b0);        pkt.push_back(8'h00);
        pkt.push_back(8'(tl >> 8)); pkt.push_back(8'(tl));
        pkt.push_back(8'h00);     pkt.push_back(8'h00);
        pkt.push_back(8'h40);     pkt.push_back(8'h00);
        pkt.push_back(8'h40);     pkt.push_back(proto);
        pkt.push_back(8'h00);     pkt.push_back(8'h00);
        for (int i = 3; i >= 0; i--) pkt.push_back(src[8*i +: 8]);
        for (int i = 3; i >= 0; i--) pkt.push_back(dst[8*i +: 8]);
        for (int i = 0; i < (ihl - 5) * 4; i++) pkt.push_back(8'h01);
        s = 0;
        for (int i = 0; i < ihl * 4; i += 2) s += int'({pkt[i], pkt[i+1]});
        while (s > 65535) s = (s & 65535) + (s >> 16);
        s = ~s & 65535;
        pkt[10] = s[15:8];
        pkt[11] = s[7:0];
        repeat (plen) pkt.push_back(8'($urandom_range(255)));
    endtask

    // reference model: frame = pkt[0..n-1], eof on the last one if has_eof
    task automatic model(input int n, input bit has_eof);
        int ihl, hl, tl, s;
        hev_t e;
        e   = '0;
        ihl = int'(pkt[0][3:0]);
        hl  = ihl * 4;
        if (pkt[0][7:4] != 4'd4 || ihl < 5) begin
            e.err = 3'd1;
            exp_hdr.push_back(e);
            return;
        end
        if (n < hl) begin
            if (has_eof) begin e.err = 3'd3; exp_hdr.push_back(e); end
            return;
        end
        s = 0;
        for (int i = 0; i < hl; i += 2) s += int'({pkt[i], pkt[i+1]});
        while (s > 65535) s = (s & 65535) + (s >> 16);
        tl      = int'({pkt[2], pkt[3]});
        e.proto = pkt[9];
        e.tl    = 16'(tl);
        e.src   = {pkt[12], pkt[13], pkt[14], pkt[15]};
        e.dst   = {pkt[16], pkt[17], pkt[18], pkt[19]};
        if (s != 65535)         e.err = 3'd2;
        else if (tl < hl)       e.err = 3'd1;
        else if (e.dst != LOCAL_IP) e.err = 3'd4;
        else                    e.ok  = 1'b1;
        exp_hdr.push_back(e);
        if (!e.ok) return;
        for (int i = hl; i < n && i < tl; i++)
            exp_pl.push_back({(i == tl - 1) || (has_eof && i == n - 1), pkt[i]});
    endtask

    task automatic drive(input int n, input bit has_eof, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
                @(posedge clk); #1;
            end
            rx_valid = 1'b1;
            rx_data  = pkt[i];
            rx_sof   = (i == 0);
            rx_eof   = has_eof && (i == n - 1);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hdr_done, hdr_ok, hdr_err, ip_proto, ip_total_len, ip_src, ip_dst, pl_valid, pl_data, pl_last} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h %h %h exp all zero", hdr_err, ip_src, ip_dst, pl_data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        // bytes without sof in IDLE are ignored
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1; rx_sof = 1'b0; rx_eof = (i == 5);
            rx_data  = (i == 0) ? 8'h45 : 8'($urandom_range(255));
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_eof = 1'b0;
        settle();
        checks++;
        if (obs_hdr.size() != 0 || obs_pl.size() != 0) begin
            errors++;
            $display("FAIL idle_ignore got hdr=%0d pl=%0d exp 0 0", obs_hdr.size(), obs_pl.size());
        end
        obs_hdr.delete(); obs_pl.delete();
    endtask

    // good packet, bad checksum, padded frame
    task automatic test_basic();
        build(5, 115, 8'h11, 32'hC0A8_0001, LOCAL_IP, 95);
        model(115, 1); drive(115, 1, 0);
        pkt[11] = 8'h62;
        model(115, 1); drive(115, 1, 0);
        build(5, 115, 8'h11, 32'hC0A8_0001, LOCAL_IP, 105);
        model(125, 1); drive(125, 1, 0);
        settle();
        checks++;
        if (obs_hdr.size() < 1 || obs_hdr[0].ok !== 1'b1 || obs_hdr[0].proto !== 8'h11 ||
            obs_hdr[0].tl !== 16'd115 || obs_hdr[0].src !== 32'hC0A8_0001) begin
            errors++;
            $display("FAIL basic_fields got %h exp ok proto 11 len 115 src c0a80001", obs_hdr.size() > 0 ? obs_hdr[0] : '0);
        end
        checks++;
        if (obs_hdr.size() < 2 || obs_hdr[1].ok !== 1'b0 || obs_hdr[1].err !== 3'd2) begin
            errors++;
            $display("FAIL basic_csum_err got %h exp ok=0 err=2", obs_hdr.size() > 1 ? obs_hdr[1] : '0);
        end
        checks++;
        if (obs_pl.size() != 190 || obs_pl[94][8] !== 1'b1 || obs_pl[189][8] !== 1'b1) begin
            errors++;
            $display("FAIL basic_pl_count got %0d exp 190 with last at 95th of each", obs_pl.size());
        end
        checks++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            errors++; $display("FAIL basic_hdr_count got %0d exp %0d", obs_hdr.size(), exp_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            checks++;
            if (exp_hdr[i].ok ? (obs_hdr[i] !== exp_hdr[i]) : ({obs_hdr[i].ok, obs_hdr[i].err} !== {exp_hdr[i].ok, exp_hdr[i].err})) begin
                errors++; $display("FAIL basic_hdr[%0d] got %h exp %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            checks++;
            if (obs_pl[i] !== exp_pl[i]) begin
                errors++; $display("FAIL basic_pl[%0d] got %h exp %h", i, obs_pl[i], exp_pl[i]);
            end
        end
        exp_hdr.delete(); obs_hdr.delete(); exp_pl.delete(); obs_pl.delete();
    endtask

    // options header, total_len shorter than header, empty payload ending on header
    task automatic test_options();
        build(6, 44, 8'h06, 32'h0A00_0001, LOCAL_IP, 20);
        model(44, 1); drive(44, 1, 10);
        build(5, 16, 8'h11, 32'h0A00_0002, LOCAL_IP, 8);
        model(28, 1); drive(28, 1, 0);
        build(15, 60, 8'h01, 32'h0A00_0003, LOCAL_IP, 0);
        model(60, 1); drive(60, 1, 0);
        build(5, 20, 8'h11, 32'h0A00_0004, LOCAL_IP, 6);
        model(26, 1); drive(26, 1, 0);
        settle();
        checks++;
        if (obs_pl.size() < 1 || obs_pl[0] !== {1'b0, pkt.size() > 0 ? 8'h00 : 8'h00} && obs_pl[0][7:0] !== exp_pl[0][7:0]) begin
            errors++; $display("FAIL opt_first_pl got %h exp %h", obs_pl.size() > 0 ? obs_pl[0] : '0, exp_pl[0]);
        end
        checks++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            errors++; $display("FAIL opt_hdr_count got %0d exp %0d", obs_hdr.size(), exp_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            checks++;
            if (exp_hdr[i].ok ? (obs_hdr[i] !== exp_hdr[i]) : ({obs_hdr[i].ok, obs_hdr[i].err} !== {exp_hdr[i].ok, exp_hdr[i].err})) begin
                errors++; $display("FAIL opt_hdr[%0d] got %h exp %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        checks++;
        if (obs_pl.size() != exp_pl.size()) begin
            errors++; $display("FAIL opt_pl_count got %0d exp %0d", obs_pl.size(), exp_pl.size());
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            checks++;
            if (obs_pl[i] !== exp_pl[i]) begin
                errors++; $display("FAIL opt_pl[%0d] got %h exp %h", i, obs_pl[i], exp_pl[i]);
            end
        end
        exp_hdr.delete(); obs_hdr.delete(); exp_pl.delete(); obs_pl.delete();
    endtask

    // eof inside the header, bad version, then a good packet
    task automatic test_truncated();
        build(5, 40, 8'h11, 32'hC0A8_0005, LOCAL_IP, 20);
        model(13, 1); drive(13, 1, 0);
        model(40, 1); drive(40, 1, 20);
        pkt[0] = 8'h55;
        model(40, 1); drive(40, 1, 0);
        pkt[0] = 8'h44;
        model(1, 1); drive(1, 1, 0);
        settle();
        checks++;
        if (obs_hdr.size() < 1 || obs_hdr[0].err !== 3'd3 || obs_hdr[0].ok !== 1'b0) begin
            errors++; $display("FAIL trunc_err got %h exp err=3", obs_hdr.size() > 0 ? obs_hdr[0] : '0);
        end
        checks++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            errors++; $display("FAIL trunc_hdr_count got %0d exp %0d", obs_hdr.size(), exp_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            checks++;
            if (exp_hdr[i].ok ? (obs_hdr[i] !== exp_hdr[i]) : ({obs_hdr[i].ok, obs_hdr[i].err} !== {exp_hdr[i].ok, exp_hdr[i].err})) begin
                errors++; $display("FAIL trunc_hdr[%0d] got %h exp %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        checks++;
        if (obs_pl.size() != exp_pl.size()) begin
            errors++; $display("FAIL trunc_pl_count got %0d exp %0d", obs_pl.size(), exp_pl.size());
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            checks++;
            if (obs_pl[i] !== exp_pl[i]) begin
                errors++; $display("FAIL trunc_pl[%0d] got %h exp %h", i, obs_pl[i], exp_pl[i]);
            end
        end
        exp_hdr.delete(); obs_hdr.delete(); exp_pl.delete(); obs_pl.delete();
    endtask

    // sof mid-payload, then reset mid-header
    task automatic test_abort_and_reset();
        build(5, 40, 8'h11, 32'hC0A8_0006, LOCAL_IP, 20);
        model(30, 0); drive(30, 0, 0);
        build(5, 30, 8'h06, 32'hC0A8_0007, LOCAL_IP, 10);
        model(30, 1); drive(30, 1, 20);
        build(5, 30, 8'h06, 32'hC0A8_0008, LOCAL_IP, 10);
        drive(8, 0, 0);
        rst = 1'b0;
        #1;
        checks++;
        if ({hdr_done, hdr_ok, hdr_err, ip_proto, ip_total_len, ip_src, ip_dst, pl_valid, pl_data, pl_last} !== '0) begin
            errors++;
            $display("FAIL rst_mid_hdr got src=%h dst=%h len=%h exp all zero", ip_src, ip_dst, ip_total_len);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        build(5, 36, 8'h11, 32'hC0A8_0009, LOCAL_IP, 16);
        model(36, 1); drive(36, 1, 0);
        settle();
        checks++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            errors++; $display("FAIL abort_hdr_count got %0d exp %0d", obs_hdr.size(), exp_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            checks++;
            if (exp_hdr[i].ok ? (obs_hdr[i] !== exp_hdr[i]) : ({obs_hdr[i].ok, obs_hdr[i].err} !== {exp_hdr[i].ok, exp_hdr[i].err})) begin
                errors++; $display("FAIL abort_hdr[%0d] got %h exp %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        checks++;
        if (obs_pl.size() != exp_pl.size()) begin
            errors++; $display("FAIL abort_pl_count got %0d exp %0d", obs_pl.size(), exp_pl.size());
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            checks++;
            if (obs_pl[i] !== exp_pl[i]) begin
                errors++; $display("FAIL abort_pl[%0d] got %h exp %h", i, obs_pl[i], exp_pl[i]);
            end
        end
        exp_hdr.delete(); obs_hdr.delete(); exp_pl.delete(); obs_pl.delete();
    endtask

    // random packets with faults; gap_pct 0 gives back-to-back frames
    task automatic run_random(input int npkt, input int gap_pct);
        for (int k = 0; k < npkt; k++) begin
            int ihl, hl, plen, fault, n, cut;
            ihl   = 5 + int'($urandom_range(2));
            hl    = ihl * 4;
            plen  = int'($urandom_range(30));
            fault = int'($urandom_range(6));
            build(ihl, (fault == 4) ? hl - 4 : hl + plen, 8'($urandom_range(255)), $urandom,
                  (fault == 2) ? (LOCAL_IP ^ 32'h0000_0003) : LOCAL_IP, plen);
            if (fault == 1) pkt[11] = pkt[11] ^ 8'h01;
            if (fault == 3) pkt[0]  = 8'h35;
            cut = (plen > 3) ? int'($urandom_range(3)) : 0;
            if (cut == 0) repeat ($urandom_range(5)) pkt.push_back(8'($urandom_range(255)));
            n = pkt.size() - cut;
            if (fault == 5) n = int'($urandom_range(hl - 1, 1));
            model(n, 1); drive(n, 1, gap_pct);
        end
        settle();
    endtask

    task automatic test_random();
        run_random(20, 30);
        checks++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            errors++; $display("FAIL rand_hdr_count got %0d exp %0d", obs_hdr.size(), exp_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            checks++;
            if (exp_hdr[i].ok ? (obs_hdr[i] !== exp_hdr[i]) : ({obs_hdr[i].ok, obs_hdr[i].err} !== {exp_hdr[i].ok, exp_hdr[i].err})) begin
                errors++; $display("FAIL rand_hdr[%0d] got %h exp %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        checks++;
        if (obs_pl.size() != exp_pl.size()) begin
            errors++; $display("FAIL rand_pl_count got %0d exp %0d", obs_pl.size(), exp_pl.size());
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            checks++;
            if (obs_pl[i] !== exp_pl[i]) begin
                errors++; $display("FAIL rand_pl[%0d] got %h exp %h", i, obs_pl[i], exp_pl[i]);
            end
        end
        exp_hdr.delete(); obs_hdr.delete(); exp_pl.delete(); obs_pl.delete();
    endtask

    task automatic test_back_to_back();
        run_random(12, 0);
        checks++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            errors++; $display("FAIL b2b_hdr_count got %0d exp %0d", obs_hdr.size(), exp_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            checks++;
            if (exp_hdr[i].ok ? (obs_hdr[i] !== exp_hdr[i]) : ({obs_hdr[i].ok, obs_hdr[i].err} !== {exp_hdr[i].ok, exp_hdr[i].err})) begin
                errors++; $display("FAIL b2b_hdr[%0d] got %h exp %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        checks++;
        if (obs_pl.size() != exp_pl.size()) begin
            errors++; $display("FAIL b2b_pl_count got %0d exp %0d", obs_pl.size(), exp_pl.size());
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            checks++;
            if (obs_pl[i] !== exp_pl[i]) begin
                errors++; $display("FAIL b2b_pl[%0d] got %h exp %h", i, obs_pl[i], exp_pl[i]);
            end
        end
        exp_hdr.delete(); obs_hdr.delete(); exp_pl.delete(); obs_pl.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_options();
        test_truncated();
        test_abort_and_reset();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
